// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller between the core load/store port and a synchronous RAM
module dmem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              err,
    output logic              stall,
    output logic              ram_ena,
    output logic [3:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] RD_CNT = 3'(RD_LAT - 1);
    localparam logic [2:0] WR_CNT = 3'(WR_LAT - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [1:0]        lane_q, lane_d;

    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              ram_ena_q, ram_ena_d;
    logic [3:0]        ram_wea_q, ram_wea_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_din_q, ram_din_d;

    logic              bad_access;

    function automatic logic is_bad(input logic [1:0] sz, input logic [1:0] ln);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = ln[0];
            SZ_WORD: bad = (ln != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] wr_mask(input logic [1:0] sz, input logic [1:0] ln);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = 4'b0001 << ln;
            SZ_HALF: m = 4'b0011 << ln;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] wr_rep(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Little-endian lane pick followed by sign or zero extension.
    function automatic logic [31:0] ld_ext(input logic [1:0] sz, input logic [1:0] ln,
                                           input logic sx, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (ln)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = ln[1] ? d[31:16] : d[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sx & b[7]}}, b};
            SZ_HALF: r = {{16{sx & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign bad_access = is_bad(size, addr[1:0]);

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            lane_q     <= 2'b00;
            rdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            ram_ena_q  <= 1'b0;
            ram_wea_q  <= 4'b0000;
            ram_addr_q <= '0;
            ram_din_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            lane_q     <= lane_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            ram_ena_q  <= ram_ena_d;
            ram_wea_q  <= ram_wea_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (bad_access) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ACC;
                        cnt_d   = we ? WR_CNT : RD_CNT;
                    end
                end
            end
            S_ACC: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Completion outputs default low so ready/err/rdata form a single-cycle pulse.
    always_comb begin
        we_d       = we_q;
        size_d     = size_q;
        sign_d     = sign_q;
        lane_d     = lane_q;
        rdata_d    = 32'd0;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        ram_ena_d  = ram_ena_q;
        ram_wea_d  = ram_wea_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d   = we;
                    size_d = size;
                    sign_d = sign_ld;
                    lane_d = addr[1:0];
                    if (bad_access) begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        ram_ena_d  = 1'b1;
                        ram_addr_d = {addr[ADDR_W-1:2], 2'b00};
                        if (we) begin
                            ram_wea_d = wr_mask(size, addr[1:0]);
                            ram_din_d = wr_rep(size, wdata);
                        end else begin
                            ram_wea_d = 4'b0000;
                        end
                    end
                end
            end
            S_ACC: begin
                if (cnt_q == 3'd0) begin
                    ready_d   = 1'b1;
                    ram_ena_d = 1'b0;
                    ram_wea_d = 4'b0000;
                    if (!we_q) begin
                        rdata_d = ld_ext(size_q, lane_q, sign_q, ram_dout);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign ram_ena  = ram_ena_q;
    assign ram_wea  = ram_wea_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign stall    = req & ~ready_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed vector bench for dmem_ctrl (single-cycle and multi-cycle instances)
module tb_dmem_ctrl;

    logic        clka = 1'b0;
    logic        rst, req, we, sign_ld;
    logic [1:0]  size;
    logic [31:0] addr, wdata, ram_dout;

    logic [31:0] rdata1, ram_addr1, ram_din1;
    logic        ready1, err1, stall1, ram_ena1;
    logic [3:0]  ram_wea1;
    logic [31:0] rdata3, ram_addr3, ram_din3;
    logic        ready3, err3, stall3, ram_ena3;
    logic [3:0]  ram_wea3;

    int checks = 0;
    int errors = 0;

    always #5 clka = ~clka;

    dmem_ctrl #(.ADDR_W(32), .RD_LAT(1), .WR_LAT(1)) u_dut1 (
        .clka(clka), .rst(rst), .req(req), .we(we), .size(size), .sign_ld(sign_ld),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .ready(ready1), .err(err1),
        .stall(stall1), .ram_ena(ram_ena1), .ram_wea(ram_wea1), .ram_addr(ram_addr1),
        .ram_din(ram_din1), .ram_dout(ram_dout)
    );

    dmem_ctrl #(.ADDR_W(32), .RD_LAT(3), .WR_LAT(2)) u_dut3 (
        .clka(clka), .rst(rst), .req(req), .we(we), .size(size), .sign_ld(sign_ld),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .ready(ready3), .err(err3),
        .stall(stall3), .ram_ena(ram_ena3), .ram_wea(ram_wea3), .ram_addr(ram_addr3),
        .ram_din(ram_din3), .ram_dout(ram_dout)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        logic [3:0]  wea;
        logic [31:0] din;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        vec[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
        vec[1]  = '{1'b1, 2'b00, 1'b0, 32'h13,  32'h000000A5, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0};
        vec[2]  = '{1'b1, 2'b01, 1'b0, 32'h22,  32'h00001234, 32'h0,        4'b1100, 32'h12341234, 32'h0,        1'b0};
        vec[3]  = '{1'b0, 2'b00, 1'b1, 32'h102, 32'h0,        32'h80FF7F01, 4'b0000, 32'h0,        32'hFFFFFFFF, 1'b0};
        vec[4]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h80FF7F01, 4'b0000, 32'h0,        32'h00000080, 1'b0};
        vec[5]  = '{1'b0, 2'b01, 1'b1, 32'h206, 32'h0,        32'h80FF7F01, 4'b0000, 32'h0,        32'hFFFF80FF, 1'b0};
        vec[6]  = '{1'b0, 2'b01, 1'b1, 32'h204, 32'h0,        32'h80FF7F01, 4'b0000, 32'h0,        32'h00007F01, 1'b0};
        vec[7]  = '{1'b0, 2'b10, 1'b1, 32'h40,  32'h0,        32'h80FF7F01, 4'b0000, 32'h0,        32'h80FF7F01, 1'b0};
        vec[8]  = '{1'b0, 2'b00, 1'b1, 32'h100, 32'h0,        32'h80FF7F01, 4'b0000, 32'h0,        32'h00000001, 1'b0};
        vec[9]  = '{1'b0, 2'b00, 1'b0, 32'h101, 32'h0,        32'h80FF7F01, 4'b0000, 32'h0,        32'h0000007F, 1'b0};
        vec[10] = '{1'b0, 2'b10, 1'b0, 32'h42,  32'h0,        32'h80FF7F01, 4'b0000, 32'h0,        32'h0,        1'b1};
        vec[11] = '{1'b0, 2'b11, 1'b0, 32'h40,  32'h0,        32'h80FF7F01, 4'b0000, 32'h0,        32'h0,        1'b1};
        vec[12] = '{1'b1, 2'b01, 1'b0, 32'h21,  32'h0000BEEF, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        vec[13] = '{1'b0, 2'b01, 1'b0, 32'h202, 32'h0,        32'h80FF7F01, 4'b0000, 32'h0,        32'h000080FF, 1'b0};
        vec[14] = '{1'b1, 2'b00, 1'b0, 32'h31,  32'h000000C3, 32'h0,        4'b0010, 32'hC3C3C3C3, 32'h0,        1'b0};

        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ld = 1'b0;
        addr = 32'h0; wdata = 32'h0; ram_dout = 32'h0;
        @(negedge clka);
        @(negedge clka);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_ready1", 32'(ready1), 32'h0);
        chk("rst_err1", 32'(err1), 32'h0);
        chk("rst_ena1", 32'(ram_ena1), 32'h0);
        chk("rst_wea1", 32'(ram_wea1), 32'h0);
        chk("rst_addr1", ram_addr1, 32'h0);
        chk("rst_din1", ram_din1, 32'h0);
        chk("rst_ready3", 32'(ready3), 32'h0);
        chk("rst_ena3", 32'(ram_ena3), 32'h0);
        rst = 1'b0;

        // Single-cycle instance: one vector per access, inputs scrambled once latched.
        for (int i = 0; i < NV; i++) begin
            v = vec[i];
            req = 1'b1; we = v.we; size = v.size; sign_ld = v.sign;
            addr = v.addr; wdata = v.wdata; ram_dout = v.dout;
            @(negedge clka);
            if (v.err) begin
                chk($sformatf("v%0d_err_ready", i), 32'(ready1), 32'h1);
                chk($sformatf("v%0d_err_err", i), 32'(err1), 32'h1);
                chk($sformatf("v%0d_err_rdata", i), rdata1, 32'h0);
                chk($sformatf("v%0d_err_ena", i), 32'(ram_ena1), 32'h0);
                chk($sformatf("v%0d_err_wea", i), 32'(ram_wea1), 32'h0);
            end else begin
                chk($sformatf("v%0d_ena", i), 32'(ram_ena1), 32'h1);
                chk($sformatf("v%0d_wea", i), 32'(ram_wea1), 32'(v.wea));
                chk($sformatf("v%0d_addr", i), ram_addr1, {v.addr[31:2], 2'b00});
                chk($sformatf("v%0d_ready_acc", i), 32'(ready1), 32'h0);
                if (v.we) chk($sformatf("v%0d_din", i), ram_din1, v.din);
                we = ~v.we; size = ~v.size; sign_ld = ~v.sign; addr = ~v.addr; wdata = ~v.wdata;
                @(negedge clka);
                chk($sformatf("v%0d_ready", i), 32'(ready1), 32'h1);
                chk($sformatf("v%0d_err", i), 32'(err1), 32'h0);
                chk($sformatf("v%0d_rdata", i), rdata1, v.rdata);
                chk($sformatf("v%0d_ena_off", i), 32'(ram_ena1), 32'h0);
                chk($sformatf("v%0d_wea_off", i), 32'(ram_wea1), 32'h0);
            end
            req = 1'b0;
            @(negedge clka);
            chk($sformatf("v%0d_ready_pulse", i), 32'(ready1), 32'h0);
            chk($sformatf("v%0d_err_pulse", i), 32'(err1), 32'h0);
        end

        rst = 1'b1;
        @(negedge clka);
        rst = 1'b0;

        // RD_LAT=3 word load, req held so a second access starts right after ready.
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ld = 1'b0; addr = 32'h40; ram_dout = 32'h13579BDF;
        #1;
        chk("t4_stall_c0", 32'(stall3), 32'h1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clka);
            chk($sformatf("t4_ena_c%0d", c), 32'(ram_ena3), 32'h1);
            chk($sformatf("t4_stall_c%0d", c), 32'(stall3), 32'h1);
            chk($sformatf("t4_ready_c%0d", c), 32'(ready3), 32'h0);
            if (c == 3) chk("t4_addr_hold", ram_addr3, 32'h40);
            if (c == 2) begin addr = 32'h80; size = 2'b00; end
        end
        @(negedge clka);
        chk("t4_ready_c4", 32'(ready3), 32'h1);
        chk("t4_rdata_c4", rdata3, 32'h13579BDF);
        chk("t4_err_c4", 32'(err3), 32'h0);
        chk("t4_ena_c4", 32'(ram_ena3), 32'h0);
        chk("t4_stall_c4", 32'(stall3), 32'h0);
        addr = 32'h40; size = 2'b10; ram_dout = 32'h2468ACE0;
        @(negedge clka);
        chk("t4_ready_c5", 32'(ready3), 32'h0);
        chk("t4_stall_c5", 32'(stall3), 32'h1);
        chk("t4_ena_c5", 32'(ram_ena3), 32'h0);
        for (int c = 6; c <= 8; c++) begin
            @(negedge clka);
            chk($sformatf("t4_ena_c%0d", c), 32'(ram_ena3), 32'h1);
            chk($sformatf("t4_ready_c%0d", c), 32'(ready3), 32'h0);
        end
        @(negedge clka);
        chk("t4_ready_c9", 32'(ready3), 32'h1);
        chk("t4_rdata_c9", rdata3, 32'h2468ACE0);
        req = 1'b0;
        @(negedge clka);
        chk("t4_ready_c10", 32'(ready3), 32'h0);

        // WR_LAT=2 byte store: strobe held for two cycles.
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h51; wdata = 32'h0000005A;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clka);
            chk($sformatf("w2_ena_c%0d", c), 32'(ram_ena3), 32'h1);
            chk($sformatf("w2_wea_c%0d", c), 32'(ram_wea3), 32'b0010);
            chk($sformatf("w2_din_c%0d", c), ram_din3, 32'h5A5A5A5A);
            chk($sformatf("w2_ready_c%0d", c), 32'(ready3), 32'h0);
        end
        @(negedge clka);
        chk("w2_ready_c3", 32'(ready3), 32'h1);
        chk("w2_wea_c3", 32'(ram_wea3), 32'h0);
        chk("w2_err_c3", 32'(err3), 32'h0);
        req = 1'b0;
        @(negedge clka);

        // Error completes in cycle 1 regardless of RD_LAT.
        req = 1'b1; we = 1'b0; size = 2'b01; addr = 32'h43;
        @(negedge clka);
        chk("e3_ready", 32'(ready3), 32'h1);
        chk("e3_err", 32'(err3), 32'h1);
        chk("e3_ena", 32'(ram_ena3), 32'h0);
        req = 1'b0;
        @(negedge clka);

        // Reset in cycle 2 of an RD_LAT=3 read aborts it without a ready pulse.
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h40; ram_dout = 32'h11111111;
        @(negedge clka);
        chk("t6_ena_c1", 32'(ram_ena3), 32'h1);
        @(negedge clka);
        chk("t6_ena_c2", 32'(ram_ena3), 32'h1);
        rst = 1'b1; req = 1'b0;
        @(negedge clka);
        chk("t6_ena_c3", 32'(ram_ena3), 32'h0);
        chk("t6_ready_c3", 32'(ready3), 32'h0);
        chk("t6_wea_c3", 32'(ram_wea3), 32'h0);
        rst = 1'b0;
        for (int c = 4; c <= 9; c++) begin
            @(negedge clka);
            chk($sformatf("t6_ready_c%0d", c), 32'(ready3), 32'h0);
            chk($sformatf("t6_ena_c%0d", c), 32'(ram_ena3), 32'h0);
        end
        req = 1'b1; ram_dout = 32'hCAFEF00D;
        for (int c = 1; c <= 3; c++) @(negedge clka);
        @(negedge clka);
        chk("t6_new_ready", 32'(ready3), 32'h1);
        chk("t6_new_rdata", rdata3, 32'hCAFEF00D);
        req = 1'b0;
        @(negedge clka);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
